// File: rtl/rv_ctrl_pkg.sv
// Shared encodings and the per-instruction control word for the pipelined RV32I/M control path.
// The all-zero control word is the pipeline bubble and the reset value of every stage register.
package rv_ctrl_pkg;

  localparam logic [4:0] ALU_ADD   = 5'd0;
  localparam logic [4:0] ALU_SUB   = 5'd1;
  localparam logic [4:0] ALU_AND   = 5'd2;
  localparam logic [4:0] ALU_OR    = 5'd3;
  localparam logic [4:0] ALU_XOR   = 5'd4;
  localparam logic [4:0] ALU_SLL   = 5'd5;
  localparam logic [4:0] ALU_SRL   = 5'd6;
  localparam logic [4:0] ALU_SRA   = 5'd7;
  localparam logic [4:0] ALU_SLT   = 5'd8;
  localparam logic [4:0] ALU_SLTU  = 5'd9;
  localparam logic [4:0] ALU_PASSB = 5'd10;
  localparam logic [4:0] ALU_MUL   = 5'd16;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [1:0] WB_MEM = 2'd0;
  localparam logic [1:0] WB_ALU = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef struct packed {
    logic       reg_wen;
    logic       mem_rw;
    logic       mem_read;
    logic       branch;
    logic       jump;
    logic       a_sel;
    logic       b_sel;
    logic       br_un;
    logic [1:0] wb_sel;
    logic [4:0] alu_ctrl;
    logic [2:0] funct3;
    logic       rs1_used;
    logic       rs2_used;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_BUBBLE = '0;

  // Base-ISA ALU code from funct3; alt selects SUB/SRA (instr[30]).
  function automatic logic [4:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    logic [4:0] code;
    case (f3)
      3'b000:  code = alt ? ALU_SUB : ALU_ADD;
      3'b001:  code = ALU_SLL;
      3'b010:  code = ALU_SLT;
      3'b011:  code = ALU_SLTU;
      3'b100:  code = ALU_XOR;
      3'b101:  code = alt ? ALU_SRA : ALU_SRL;
      3'b110:  code = ALU_OR;
      default: code = ALU_AND;
    endcase
    return code;
  endfunction

  // A producer stage hits a consumer source when it writes a non-x0 register that source reads.
  function automatic logic raw_hit(input logic wen, input logic [4:0] rd,
                                   input logic used, input logic [4:0] rs);
    return wen && (rd != 5'd0) && used && (rd == rs);
  endfunction

endpackage

// File: rtl/rv_ctrl_decode.sv
// Combinational RV32I (+ optional RV32M) decoder: instruction word to control word and immediate format.
// Anything not decodable, or not valid, leaves as an all-zero bubble.
module rv_ctrl_decode
  import rv_ctrl_pkg::*;
#(
  parameter bit MEXT = 1'b1
) (
  input  logic [31:0] instr,
  input  logic        valid,
  output ctrl_word_t  ctrl,
  output logic [2:0]  imm_sel,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  ctrl_word_t c;
  logic       legal;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];

  always_comb begin
    c         = CTRL_BUBBLE;
    legal     = 1'b0;
    imm_sel   = IMM_I;
    c.funct3  = f3;
    c.rs1     = instr[19:15];
    c.rs2     = instr[24:20];
    case (opcode)
      OPC_LUI: begin
        legal = 1'b1; imm_sel = IMM_U;
        c.reg_wen = 1'b1; c.b_sel = 1'b1; c.alu_ctrl = ALU_PASSB; c.wb_sel = WB_ALU;
        c.rd = instr[11:7];
      end
      OPC_AUIPC: begin
        legal = 1'b1; imm_sel = IMM_U;
        c.reg_wen = 1'b1; c.a_sel = 1'b1; c.b_sel = 1'b1; c.wb_sel = WB_ALU;
        c.rd = instr[11:7];
      end
      OPC_JAL: begin
        legal = 1'b1; imm_sel = IMM_J;
        c.reg_wen = 1'b1; c.jump = 1'b1; c.a_sel = 1'b1; c.b_sel = 1'b1; c.wb_sel = WB_PC4;
        c.rd = instr[11:7];
      end
      OPC_JALR: begin
        legal = (f3 == 3'b000); imm_sel = IMM_I;
        c.reg_wen = 1'b1; c.jump = 1'b1; c.b_sel = 1'b1; c.wb_sel = WB_PC4;
        c.rs1_used = 1'b1; c.rd = instr[11:7];
      end
      OPC_BRANCH: begin
        legal = (f3 != 3'b010) && (f3 != 3'b011); imm_sel = IMM_B;
        c.branch = 1'b1; c.a_sel = 1'b1; c.b_sel = 1'b1; c.br_un = f3[1];
        c.rs1_used = 1'b1; c.rs2_used = 1'b1;
      end
      OPC_LOAD: begin
        legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                (f3 == 3'b100) || (f3 == 3'b101);
        c.reg_wen = 1'b1; c.mem_read = 1'b1; c.b_sel = 1'b1; c.wb_sel = WB_MEM;
        c.rs1_used = 1'b1; c.rd = instr[11:7];
      end
      OPC_STORE: begin
        legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010); imm_sel = IMM_S;
        c.mem_rw = 1'b1; c.b_sel = 1'b1;
        c.rs1_used = 1'b1; c.rs2_used = 1'b1;
      end
      OPC_OPIMM: begin
        // Shift-immediates reuse funct7 as a qualifier; other OP-IMM forms carry immediate bits there.
        if (f3 == 3'b001)      legal = (f7 == 7'b0000000);
        else if (f3 == 3'b101) legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
        else                   legal = 1'b1;
        c.reg_wen = 1'b1; c.b_sel = 1'b1; c.wb_sel = WB_ALU;
        c.alu_ctrl = alu_from_f3(f3, (f3 == 3'b101) && instr[30]);
        c.rs1_used = 1'b1; c.rd = instr[11:7];
      end
      OPC_OP: begin
        if (f7 == 7'b0000000) begin
          legal = 1'b1; c.alu_ctrl = alu_from_f3(f3, 1'b0);
        end else if (f7 == 7'b0100000) begin
          legal = (f3 == 3'b000) || (f3 == 3'b101); c.alu_ctrl = alu_from_f3(f3, 1'b1);
        end else if (f7 == 7'b0000001) begin
          legal = MEXT; c.alu_ctrl = ALU_MUL | {2'b00, f3};
        end
        c.reg_wen = 1'b1; c.wb_sel = WB_ALU;
        c.rs1_used = 1'b1; c.rs2_used = 1'b1; c.rd = instr[11:7];
      end
      default: legal = 1'b0;
    endcase
    illegal = valid && !legal;
    ctrl    = (valid && legal) ? c : CTRL_BUBBLE;
  end

endmodule

// File: rtl/rv_pipe_ctrl.sv
// Pipelined control: decodes in ID, carries control words through ID/EX, EX/MEM, MEM/WB,
// and resolves load-use / RAW / MDU stalls, redirect flushes and operand forwarding.
module rv_pipe_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter bit MEXT       = 1'b1,
  parameter bit FORWARDING = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_id,
  input  logic        valid_id,
  input  logic        br_taken_ex,
  input  logic        mdu_busy_ex,
  output logic [2:0]  ImmSel_id,
  output logic        illegal_id,
  output logic        stall_o,
  output logic        flush_o,
  output logic        ASel_ex,
  output logic        BSel_ex,
  output logic        BrUn_ex,
  output logic [4:0]  ALUControl_ex,
  output logic [1:0]  fwd_a_ex,
  output logic [1:0]  fwd_b_ex,
  output logic        PCSel_ex,
  output logic        MemRW_mem,
  output logic [2:0]  funct3_mem,
  output logic        RegWEn_wb,
  output logic [1:0]  WBSel_wb,
  output logic [4:0]  rd_wb
);

  ctrl_word_t id_c, ex_q, mem_q, wb_q, ex_d, mem_d;
  logic ex_hit, mem_hit, wb_hit, data_hazard, data_stall, redirect;
  logic unused_fields;

  rv_ctrl_decode #(.MEXT(MEXT)) u_decode (
    .instr   (instr_id),
    .valid   (valid_id),
    .ctrl    (id_c),
    .imm_sel (ImmSel_id),
    .illegal (illegal_id)
  );

  always_comb begin
    ex_hit  = raw_hit(ex_q.reg_wen, ex_q.rd, id_c.rs1_used, id_c.rs1) ||
              raw_hit(ex_q.reg_wen, ex_q.rd, id_c.rs2_used, id_c.rs2);
    mem_hit = raw_hit(mem_q.reg_wen, mem_q.rd, id_c.rs1_used, id_c.rs1) ||
              raw_hit(mem_q.reg_wen, mem_q.rd, id_c.rs2_used, id_c.rs2);
    wb_hit  = raw_hit(wb_q.reg_wen, wb_q.rd, id_c.rs1_used, id_c.rs1) ||
              raw_hit(wb_q.reg_wen, wb_q.rd, id_c.rs2_used, id_c.rs2);
    data_hazard = FORWARDING ? (ex_hit && ex_q.mem_read) : (ex_hit || mem_hit || wb_hit);
    // A stalled MDU op owns EX, so its redirect cannot fire; a redirect overrides a data stall.
    redirect   = !mdu_busy_ex && ((ex_q.branch && br_taken_ex) || ex_q.jump);
    data_stall = data_hazard && !redirect;
    stall_o    = mdu_busy_ex || data_stall;
    flush_o    = redirect;
    PCSel_ex   = redirect;
  end

  always_comb begin
    ex_d  = id_c;
    mem_d = ex_q;
    if (mdu_busy_ex) begin
      ex_d  = ex_q;
      mem_d = CTRL_BUBBLE;
    end else if (redirect || data_stall) begin
      ex_d  = CTRL_BUBBLE;
    end
  end

  always_comb begin
    fwd_a_ex = 2'b00;
    fwd_b_ex = 2'b00;
    if (FORWARDING) begin
      if (raw_hit(mem_q.reg_wen, mem_q.rd, ex_q.rs1_used, ex_q.rs1))      fwd_a_ex = 2'b01;
      else if (raw_hit(wb_q.reg_wen, wb_q.rd, ex_q.rs1_used, ex_q.rs1))   fwd_a_ex = 2'b10;
      if (raw_hit(mem_q.reg_wen, mem_q.rd, ex_q.rs2_used, ex_q.rs2))      fwd_b_ex = 2'b01;
      else if (raw_hit(wb_q.reg_wen, wb_q.rd, ex_q.rs2_used, ex_q.rs2))   fwd_b_ex = 2'b10;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= CTRL_BUBBLE;
      mem_q <= CTRL_BUBBLE;
      wb_q  <= CTRL_BUBBLE;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= mem_q;
    end
  end

  assign ASel_ex       = ex_q.a_sel;
  assign BSel_ex       = ex_q.b_sel;
  assign BrUn_ex       = ex_q.br_un;
  assign ALUControl_ex = ex_q.alu_ctrl;
  assign MemRW_mem     = mem_q.mem_rw;
  assign funct3_mem    = mem_q.funct3;
  assign RegWEn_wb     = wb_q.reg_wen;
  assign WBSel_wb      = wb_q.wb_sel;
  assign rd_wb         = wb_q.rd;

  // Later stages carry the full word for debug visibility even though only a few fields leave.
  assign unused_fields = ^{mem_q, wb_q};

endmodule

// File: tb/tb_rv_pipe_ctrl.sv
// Directed bench for rv_pipe_ctrl: default config plus FORWARDING=0 and MEXT=0 instances on shared inputs.
module tb_rv_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr_id;
  logic        valid_id, br_taken_ex, mdu_busy_ex;

  logic [2:0] immsel, nf_immsel, nm_immsel;
  logic       illegal, nf_illegal, nm_illegal;
  logic       stall, nf_stall, nm_stall;
  logic       flush, nf_flush, nm_flush;
  logic       asel, nf_asel, nm_asel, bsel, nf_bsel, nm_bsel, brun, nf_brun, nm_brun;
  logic [4:0] aluc, nf_aluc, nm_aluc;
  logic [1:0] fwda, nf_fwda, nm_fwda, fwdb, nf_fwdb, nm_fwdb;
  logic       pcsel, nf_pcsel, nm_pcsel, memrw, nf_memrw, nm_memrw;
  logic [2:0] f3mem, nf_f3mem, nm_f3mem;
  logic       regwen, nf_regwen, nm_regwen;
  logic [1:0] wbsel, nf_wbsel, nm_wbsel;
  logic [4:0] rdwb, nf_rdwb, nm_rdwb;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  rv_pipe_ctrl dut (
    .clk(clk), .rst_n(rst_n), .instr_id(instr_id), .valid_id(valid_id),
    .br_taken_ex(br_taken_ex), .mdu_busy_ex(mdu_busy_ex),
    .ImmSel_id(immsel), .illegal_id(illegal), .stall_o(stall), .flush_o(flush),
    .ASel_ex(asel), .BSel_ex(bsel), .BrUn_ex(brun), .ALUControl_ex(aluc),
    .fwd_a_ex(fwda), .fwd_b_ex(fwdb), .PCSel_ex(pcsel), .MemRW_mem(memrw),
    .funct3_mem(f3mem), .RegWEn_wb(regwen), .WBSel_wb(wbsel), .rd_wb(rdwb)
  );

  rv_pipe_ctrl #(.MEXT(1'b1), .FORWARDING(1'b0)) dut_nf (
    .clk(clk), .rst_n(rst_n), .instr_id(instr_id), .valid_id(valid_id),
    .br_taken_ex(br_taken_ex), .mdu_busy_ex(mdu_busy_ex),
    .ImmSel_id(nf_immsel), .illegal_id(nf_illegal), .stall_o(nf_stall), .flush_o(nf_flush),
    .ASel_ex(nf_asel), .BSel_ex(nf_bsel), .BrUn_ex(nf_brun), .ALUControl_ex(nf_aluc),
    .fwd_a_ex(nf_fwda), .fwd_b_ex(nf_fwdb), .PCSel_ex(nf_pcsel), .MemRW_mem(nf_memrw),
    .funct3_mem(nf_f3mem), .RegWEn_wb(nf_regwen), .WBSel_wb(nf_wbsel), .rd_wb(nf_rdwb)
  );

  rv_pipe_ctrl #(.MEXT(1'b0), .FORWARDING(1'b1)) dut_nm (
    .clk(clk), .rst_n(rst_n), .instr_id(instr_id), .valid_id(valid_id),
    .br_taken_ex(br_taken_ex), .mdu_busy_ex(mdu_busy_ex),
    .ImmSel_id(nm_immsel), .illegal_id(nm_illegal), .stall_o(nm_stall), .flush_o(nm_flush),
    .ASel_ex(nm_asel), .BSel_ex(nm_bsel), .BrUn_ex(nm_brun), .ALUControl_ex(nm_aluc),
    .fwd_a_ex(nm_fwda), .fwd_b_ex(nm_fwdb), .PCSel_ex(nm_pcsel), .MemRW_mem(nm_memrw),
    .funct3_mem(nm_f3mem), .RegWEn_wb(nm_regwen), .WBSel_wb(nm_wbsel), .rd_wb(nm_rdwb)
  );

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  // Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
  task automatic applyStimulus(input logic [31:0] instr, input logic valid,
                               input logic br, input logic busy);
    @(posedge clk);
    #1;
    instr_id    = instr;
    valid_id    = valid;
    br_taken_ex = br;
    mdu_busy_ex = busy;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  logic [31:0] add1, add2, lw5, add6, beq12, add9, jal1, div7, sw2;

  initial begin
    add1  = rtype(7'b0000000, 5'd3, 5'd2, 3'b000, 5'd1);
    add2  = rtype(7'b0000000, 5'd5, 5'd1, 3'b000, 5'd4);
    lw5   = {12'd0, 5'd1, 3'b010, 5'd5, 7'b0000011};
    add6  = rtype(7'b0000000, 5'd0, 5'd5, 3'b000, 5'd6);
    beq12 = {7'd0, 5'd2, 5'd1, 3'b000, 5'd8, 7'b1100011};
    add9  = rtype(7'b0000000, 5'd1, 5'd1, 3'b000, 5'd9);
    jal1  = {20'd0, 5'd1, 7'b1101111};
    div7  = rtype(7'b0000001, 5'd9, 5'd8, 3'b100, 5'd7);
    sw2   = {7'd0, 5'd2, 5'd1, 3'b010, 5'd0, 7'b0100011};

    rst_n = 1'b0; instr_id = '0; valid_id = 1'b0; br_taken_ex = 1'b0; mdu_busy_ex = 1'b0;
    #2;
    $display("[TB] reset state");
    checkOutput("rst_regwen_wb", regwen, 0);
    checkOutput("rst_rd_wb", rdwb, 0);
    checkOutput("rst_stall", stall, 0);
    checkOutput("rst_alu_ex", aluc, 0);
    @(negedge clk); rst_n = 1'b1;

    $display("[TB] forwarding from MEM");
    applyStimulus(add1, 1'b1, 1'b0, 1'b0);
    checkOutput("add1_stall", stall, 0);
    checkOutput("add1_illegal", illegal, 0);
    applyStimulus(add2, 1'b1, 1'b0, 1'b0);
    checkOutput("add2_id_stall", stall, 0);
    checkOutput("add1_ex_alu", aluc, 0);
    applyStimulus('0, 1'b0, 1'b0, 1'b0);
    checkOutput("add2_ex_fwd_a", fwda, 2'b01);
    checkOutput("add2_ex_fwd_b", fwdb, 2'b00);
    checkOutput("add2_ex_stall", stall, 0);
    applyStimulus('0, 1'b0, 1'b0, 1'b0);
    checkOutput("add1_wb_regwen", regwen, 1);
    checkOutput("add1_wb_rd", rdwb, 1);
    checkOutput("add1_wb_wbsel", wbsel, 1);

    $display("[TB] load-use stall");
    applyStimulus(lw5, 1'b1, 1'b0, 1'b0);
    checkOutput("lw_immsel", immsel, 0);
    checkOutput("lw_id_stall", stall, 0);
    applyStimulus(add6, 1'b1, 1'b0, 1'b0);
    checkOutput("loaduse_stall", stall, 1);
    checkOutput("loaduse_flush", flush, 0);
    applyStimulus(add6, 1'b1, 1'b0, 1'b0);
    checkOutput("loaduse_released", stall, 0);
    checkOutput("bubble_ex_bsel", bsel, 0);
    applyStimulus('0, 1'b0, 1'b0, 1'b0);
    checkOutput("add6_fwd_a", fwda, 2'b10);
    checkOutput("add6_fwd_b", fwdb, 2'b00);
    checkOutput("lw_wb_rd", rdwb, 5);
    checkOutput("lw_wb_wbsel", wbsel, 0);
    applyStimulus('0, 1'b0, 1'b0, 1'b0);
    checkOutput("bubble_wb_regwen", regwen, 0);
    checkOutput("bubble_wb_rd", rdwb, 0);

    $display("[TB] taken branch and jal");
    applyStimulus(beq12, 1'b1, 1'b0, 1'b0);
    checkOutput("beq_immsel", immsel, 2);
    applyStimulus(add9, 1'b1, 1'b1, 1'b0);
    checkOutput("beq_pcsel", pcsel, 1);
    checkOutput("beq_flush", flush, 1);
    checkOutput("beq_asel", asel, 1);
    checkOutput("beq_brun", brun, 0);
    applyStimulus(jal1, 1'b1, 1'b0, 1'b0);
    checkOutput("flushed_ex_asel", asel, 0);
    checkOutput("flushed_ex_pcsel", pcsel, 0);
    checkOutput("jal_immsel", immsel, 4);
    applyStimulus('0, 1'b0, 1'b0, 1'b0);
    checkOutput("jal_pcsel", pcsel, 1);
    checkOutput("jal_flush", flush, 1);
    applyStimulus('0, 1'b0, 1'b0, 1'b0);
    applyStimulus('0, 1'b0, 1'b0, 1'b0);
    checkOutput("jal_wb_wbsel", wbsel, 2);
    checkOutput("jal_wb_rd", rdwb, 1);
    checkOutput("jal_wb_regwen", regwen, 1);

    $display("[TB] MDU stall");
    applyStimulus(div7, 1'b1, 1'b0, 1'b0);
    checkOutput("div_illegal_mext1", illegal, 0);
    checkOutput("div_illegal_mext0", nm_illegal, 1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus('0, 1'b0, 1'b0, 1'b1);
      checkOutput($sformatf("div_hold_alu_%0d", i), aluc, 20);
      checkOutput($sformatf("div_busy_stall_%0d", i), stall, 1);
      if (i == 0) checkOutput("div_mext0_bubble_alu", nm_aluc, 0);
    end
    applyStimulus('0, 1'b0, 1'b0, 1'b0);
    checkOutput("div_done_alu", aluc, 20);
    checkOutput("div_done_stall", stall, 0);
    applyStimulus('0, 1'b0, 1'b0, 1'b0);
    checkOutput("mdu_bubble_wb_regwen", regwen, 0);
    applyStimulus('0, 1'b0, 1'b0, 1'b0);
    checkOutput("div_wb_regwen", regwen, 1);
    checkOutput("div_wb_rd", rdwb, 7);

    $display("[TB] reset with store in MEM");
    applyStimulus(sw2, 1'b1, 1'b0, 1'b0);
    checkOutput("sw_immsel", immsel, 1);
    applyStimulus('0, 1'b0, 1'b0, 1'b0);
    applyStimulus('0, 1'b0, 1'b0, 1'b0);
    checkOutput("sw_mem_memrw", memrw, 1);
    checkOutput("sw_mem_funct3", f3mem, 2);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_memrw", memrw, 0);
    checkOutput("async_rst_funct3", f3mem, 0);
    checkOutput("async_rst_regwen_wb", regwen, 0);
    checkOutput("async_rst_wbsel", wbsel, 0);
    checkOutput("async_rst_rd_wb", rdwb, 0);
    @(negedge clk); rst_n = 1'b1;

    $display("[TB] no forwarding RAW");
    applyStimulus(add1, 1'b1, 1'b0, 1'b0);
    checkOutput("nf_add1_stall", nf_stall, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(add2, 1'b1, 1'b0, 1'b0);
      checkOutput($sformatf("nf_raw_stall_%0d", i), nf_stall, 1);
      checkOutput($sformatf("nf_fwd_a_%0d", i), nf_fwda, 2'b00);
      if (i == 0) checkOutput("fwd_cfg_no_stall", stall, 0);
    end
    applyStimulus(add2, 1'b1, 1'b0, 1'b0);
    checkOutput("nf_raw_released", nf_stall, 0);
    applyStimulus('0, 1'b0, 1'b0, 1'b0);
    checkOutput("nf_add2_ex_fwd_a", nf_fwda, 2'b00);
    checkOutput("nf_add2_ex_bsel", nf_bsel, 0);
    applyStimulus('0, 1'b0, 1'b0, 1'b0);
    checkOutput("nf_add2_mem_next_stall", nf_stall, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/rv_pipe_ctrl.md
# rv_pipe_ctrl

Pipelined successor to the single-cycle RV32I control unit. It decodes the instruction in ID and carries its control word through the ID/EX, EX/MEM and MEM/WB registers. It also detects load-use and multi-cycle-unit hazards, generates forwarding selects, and squashes wrong-path instructions on taken branches and jumps. It sits between the IF/ID register and the 5-stage datapath; the datapath owns the data registers and this block owns every control register.

## Interface

- `MEXT`, default 1: decode the RV32M encodings (`funct7=0000001`, OP) into MDU ALU codes. When 0, these encodings are illegal.
- `FORWARDING`, default 1: when 0, there is no bypass; stall on any RAW against EX, MEM or WB, and `fwd_a_ex`/`fwd_b_ex` are tied to 0.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: one clock; reset is asynchronous and active-low.
- `instr_id` in 32: instruction held in the IF/ID register.
- `valid_id` in 1: IF/ID holds a real instruction; 0 is treated as a bubble.
- `br_taken_ex` in 1: branch comparator result for the instruction in EX.
- `mdu_busy_ex` in 1: multi-cycle MUL/DIV in EX has not finished.
- `ImmSel_id` out 3: I=0, S=1, B=2, U=3, J=4; combinational from `instr_id`.
- `illegal_id` out 1: valid, undecodable instruction in ID (combinational).
- `stall_o` out 1: hold PC and IF/ID.
- `flush_o` out 1: overwrite IF/ID with a bubble.
- `ASel_ex`, `BSel_ex`, `BrUn_ex` out 1 each: EX operand and compare controls.
- `ALUControl_ex` out 5: code from the shared package.
- `fwd_a_ex`, `fwd_b_ex` out 2 each: 00 = regfile, 01 = EX/MEM ALU result, 10 = MEM/WB write-back value.
- `PCSel_ex` out 1: redirect PC to the ALU target.
- `MemRW_mem` out 1: store enable.
- `funct3_mem` out 3: access size and sign.
- `RegWEn_wb` out 1: register write enable.
- `WBSel_wb` out 2: 0 = memory, 1 = ALU, 2 = PC+4.
- `rd_wb` out 5: destination register.

## Operation

- **Decode (ID).** Decode the opcode, `funct3` and `funct7` into a control word: RegWEn, MemRW, mem-read, branch, jump, ASel, BSel, BrUn, WBSel, ALUControl, `funct3`, rs1/rs2 used, rs1, rs2, rd.
  - An illegal or not-valid instruction produces a bubble: all enables 0 and rd=0.
- **ALU codes.** ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9, PASSB=10 (LUI).
  - MUL..REMU = 16..23, in ISA `funct3` order.
- **Bubble.** An all-zero control word. It is also the reset value of every pipeline register.
- **Load-use stall** (FORWARDING=1). Stall when all of the following hold:
  - EX holds a load with rd≠0;
  - rd equals a used rs1/rs2 of ID.
  - Effect: `stall_o=1`, ID/EX loads a bubble, and EX/MEM and MEM/WB advance.
- **RAW stall** (FORWARDING=0). Stall while EX, MEM or WB holds RegWEn=1 with rd≠0 matching a used ID source. Same action as the load-use stall.
- **MDU stall.** While `mdu_busy_ex=1`:
  - `stall_o=1`;
  - ID/EX holds its value, EX/MEM loads a bubble, and MEM/WB advances.
- **Redirect.** `PCSel_ex = (branch_ex & br_taken_ex) | jump_ex`. When it is 1, `flush_o=1` and ID/EX loads a bubble.
- **Forwarding.** For each EX source:
  - Select 01 if the MEM stage has RegWEn=1, rd≠0 and rd matches the source.
  - Otherwise select 10 if the WB stage matches under the same rule.
  - Otherwise select 00. MEM has priority over WB.
- **Register x0.** rd=0 never stalls and never forwards.
- **Simultaneous events:**
  - Redirect and load-use stall together: the flush wins, so `stall_o=0` and ID/EX loads a bubble.
  - MDU busy holds the EX instruction, so `PCSel_ex` is forced to 0 while `mdu_busy_ex=1`.

## Timing

- ID outputs, `stall_o`, `flush_o`, `PCSel_ex` and the `fwd_*` selects are combinational within the cycle.
- Every other `*_ex`, `*_mem` and `*_wb` output is a registered stage field.
- Latency: an instruction's control word appears on the EX outputs 1 cycle after ID, MEM after 2 cycles and WB after 3 cycles, with no stalls.
- Load-use costs exactly 1 bubble. A back-to-back RAW with FORWARDING=0 costs 3 bubbles.
- Reset: `rst_n` low clears all stage registers to a bubble immediately, without waiting for a clock edge.
  - Every registered output reads 0; `rd_wb` reads 0.
  - This holds mid-operation, including a store in MEM, where `MemRW_mem` drops at once.

## Structure

- Package `rv_ctrl_pkg` holds:
  - ALU code constants, ImmSel and WBSel encodings, and opcode constants;
  - the `ctrl_word_t` struct;
  - the `CTRL_BUBBLE` constant.
- Sub-module `rv_ctrl_decode`: the purely combinational instruction-to-`ctrl_word_t` decoder, parameterised by `MEXT`. The top holds the stage registers, hazard logic and forwarding.

## Test plan

- **Forwarding from MEM.** `add x1,x2,x3` then `add x4,x1,x5` → `fwd_a_ex=01` in the second instruction's EX cycle; `stall_o` never asserts.
- **Load-use stall.** `lw x5,0(x1)` then `add x6,x5,x0` → `stall_o=1` for 1 cycle; the bubble reaches EX with `RegWEn=0`; then `fwd_a_ex=10`.
- **Taken branch.** `beq` with `br_taken_ex=1` → `PCSel_ex=1` and `flush_o=1` in the same cycle; the next EX cycle carries a bubble. `jal x1` → `WBSel_wb=2`, `rd_wb=1`.
- **No forwarding.** FORWARDING=0, back-to-back dependent `add`s → `stall_o=1` for 3 cycles; `fwd_*` stay 00.
- **MDU stall.** MEXT=1, `div x7,x8,x9` with `mdu_busy_ex` high for 4 cycles → `ALUControl_ex=20` is held, `stall_o=1` for 4 cycles, and 4 bubbles enter MEM. With MEXT=0 the same encoding gives `illegal_id=1` and a bubble.
- **Reset mid-operation.** Assert `rst_n` low with `sw` in MEM → `MemRW_mem=0` before the next edge; all `*_wb` outputs read 0.
